mac_step_ctrl: RTL and testbench
================================

# mac_step_ctrl

Operation sequencer for the floating-point MAC datapath. It replaces the divided, derived board clock with a programmable clock-enable tick in the single system clock domain. The tick paces a run of `n_ops` multiply-accumulate operations: free-running at the tick rate, or one operation per push-button step. It clears the accumulator at run start and handshakes each operation with the MAC.

## Interface
- `DIV_W`, 26: width of the tick divider terminal count.
- `OPS_W`, 8: width of the operation count and index.

Ports:
- `clk` in 1: system clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `div_max` in DIV_W: tick period minus one; latched on start.
- `n_ops` in OPS_W: operations per run; latched on start.
- `run_mode` in 1: 1 = free-run on tick, 0 = single-step; latched on start.
- `start` in 1: level, sampled in IDLE only.
- `step` in 1: synchronous button level; the rising edge is detected internally.
- `abort` in 1: cancels a run.
- `mac_ready` in 1: MAC accepts an operation.
- `mac_done` in 1: one-cycle completion pulse from the MAC.
- `mac_valid` out 1: operation request.
- `mac_clr` out 1: one-cycle accumulator clear.
- `op_idx` out OPS_W: index of the current operation.
- `tick` out 1: divider strobe.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle run-complete pulse.

## Operation
- **Reset values:** state IDLE; divider counter, `op_idx`, latched registers and step-edge register all 0; every output 0.
- **Divider:**
  - Counter is held at 0 in IDLE, CLEAR and FINISH.
  - Otherwise it counts 0..div_max_l and wraps to 0.
  - `tick` = counting state && cnt == div_max_l.
  - div_max = 0 gives a tick every counting cycle.
- **Step edge:** `step_edge` = step && !step_q, where step_q is registered every cycle.
- **FSM:**
  - IDLE: on start, latch the inputs, clear `op_idx` and go to FINISH if n_ops == 0, else CLEAR.
  - CLEAR: `mac_clr` = 1 for this cycle, then go to WAIT_TICK.
  - WAIT_TICK: go to ISSUE on (run_mode_l && tick) || (!run_mode_l && step_edge).
  - ISSUE: `mac_valid` = 1; stay until mac_ready, then go to WAIT_DONE.
  - WAIT_DONE: on mac_done, go to FINISH if op_idx == n_ops_l - 1, else increment op_idx and go to WAIT_TICK.
  - FINISH: `done` = 1 for this cycle, then go to IDLE.
- **Outputs** are decoded from the registered state only; they do not depend combinationally on inputs, except `tick`, which is decoded from the counter.
- **Abort:** in any state other than IDLE, abort forces IDLE on the next edge and takes priority over every other transition. There is no `done` pulse, and `op_idx` holds its value.
- **Boundaries:**
  - `start` while busy is ignored.
  - Changes to `div_max`, `n_ops` or `run_mode` during a run are ignored.
  - Ticks and step edges outside WAIT_TICK are dropped, not queued.
  - `mac_done` outside WAIT_DONE is ignored.
  - `mac_done` in the same cycle as the ISSUE handshake is ignored; completion counts only in WAIT_DONE.
  - `op_idx` never exceeds n_ops_l - 1; n_ops = 2^OPS_W - 1 is supported without wrap.
  - The divider wraps at div_max_l regardless of FSM state, so tick spacing stays periodic through ISSUE and WAIT_DONE.
- **Reset mid-operation:** immediate return to reset values, including deassertion of `mac_valid`.

## Timing
- Start sampled at edge 0: CLEAR (mac_clr) in cycle 1, WAIT_TICK from cycle 2 with cnt = 0.
- First tick arrives in cycle 2 + div_max_l; ISSUE follows one cycle later.
- Request-to-accept latency is 0 cycles when mac_ready is already high in the ISSUE cycle.
- With zero-latency MAC completion in the cycle after acceptance, back-to-back ops in free-run are spaced div_max_l + 1 cycles, provided div_max_l ≥ 2.
- `done` appears one cycle after the final mac_done; `busy` drops the following cycle.
- n_ops = 0: `done` in cycle 1, IDLE in cycle 2, no mac_clr.

## Test plan
- **Reset:** assert rst_n low mid-cycle -> all outputs 0 immediately; busy 0.
- **Free-run:** div_max = 4, n_ops = 3, run_mode = 1, mac_ready tied high, mac_done one cycle after accept -> mac_clr in cycle 1; mac_valid in cycles 7, 12 and 17 with op_idx 0, 1, 2; done in cycle 19 exactly once.
- **Single-step:** run_mode = 0, n_ops = 2, step held high for 10 cycles, then low, then high again -> exactly one op per rising edge; done after the second completion.
- **Backpressure:** mac_ready low for 7 cycles in ISSUE -> mac_valid held high 8 cycles; op_idx stable; the single accept is on the 8th cycle.
- **Zero ops:** n_ops = 0 -> done in cycle 1; mac_valid and mac_clr never assert.
- **Abort and restart:** abort asserted in WAIT_DONE of op 1 -> IDLE next cycle, no done. A new start then pulses mac_clr and restarts with op_idx = 0.

Source files
------------

// File: rtl/mac_step_ctrl.sv
// mac_step_ctrl
// Operation sequencer for the floating-point MAC datapath. A programmable
// clock-enable tick, derived in the single system clock domain, paces a run
// of n_ops multiply-accumulate operations. The run is either free-running at
// the tick rate or advanced one operation per rising edge of a step button.
// The accumulator is cleared at run start and every operation is
// handshaked with the MAC.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   div_max      tick period minus one, latched on start
//   n_ops        operations per run, latched on start
//   run_mode     1 = free-run on tick, 0 = single-step, latched on start
//   start        level, sampled only while idle
//   step         synchronous button level, rising edge detected here
//   abort        cancels a run in progress
//   mac_ready    MAC accepts the current request
//   mac_done     one-cycle completion pulse from the MAC
//   mac_valid    operation request
//   mac_clr      one-cycle accumulator clear
//   op_idx       index of the current operation
//   tick         divider strobe
//   busy         a run is in progress
//   done         one-cycle run-complete pulse
module mac_step_ctrl #(
    parameter int DIV_W = 26,
    parameter int OPS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_max,
    input  logic [OPS_W-1:0] n_ops,
    input  logic             run_mode,
    input  logic             start,
    input  logic             step,
    input  logic             abort,
    input  logic             mac_ready,
    input  logic             mac_done,
    output logic             mac_valid,
    output logic             mac_clr,
    output logic [OPS_W-1:0] op_idx,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_TICK,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OPS_W-1:0] op_idx_q, op_idx_d;
    logic [DIV_W-1:0] div_max_q, div_max_d;
    logic [OPS_W-1:0] n_ops_q, n_ops_d;
    logic             run_mode_q, run_mode_d;
    logic             step_q, step_d;

    logic             counting;
    logic             tick_int;
    logic             step_edge;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_idx_q   <= '0;
            div_max_q  <= '0;
            n_ops_q    <= '0;
            run_mode_q <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_idx_q   <= op_idx_d;
            div_max_q  <= div_max_d;
            n_ops_q    <= n_ops_d;
            run_mode_q <= run_mode_d;
            step_q     <= step_d;
        end
    end

    // The divider runs through WAIT_TICK, ISSUE and WAIT_DONE so that tick
    // spacing stays periodic while an operation is in flight.
    always_comb begin
        counting  = (state_q == WAIT_TICK) || (state_q == ISSUE) ||
                    (state_q == WAIT_DONE);
        tick_int  = counting && (cnt_q == div_max_q);
        step_edge = step && !step_q;
        step_d    = step;
        if (!counting || tick_int) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Next-state logic. Abort outranks every other transition outside IDLE
    // and leaves op_idx untouched.
    always_comb begin
        state_d    = state_q;
        op_idx_d   = op_idx_q;
        div_max_d  = div_max_q;
        n_ops_d    = n_ops_q;
        run_mode_d = run_mode_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_max_d  = div_max;
                        n_ops_d    = n_ops;
                        run_mode_d = run_mode;
                        op_idx_d   = '0;
                        state_d    = (n_ops == '0) ? FINISH : CLEAR;
                    end
                end
                CLEAR: begin
                    state_d = WAIT_TICK;
                end
                WAIT_TICK: begin
                    if ((run_mode_q && tick_int) || (!run_mode_q && step_edge)) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (mac_ready) begin
                        state_d = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mac_done) begin
                        if (op_idx_q == n_ops_q - OPS_W'(1)) begin
                            state_d = FINISH;
                        end else begin
                            op_idx_d = op_idx_q + OPS_W'(1);
                            state_d  = WAIT_TICK;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs come from the registered state; only tick uses the counter.
    always_comb begin
        mac_valid = (state_q == ISSUE);
        mac_clr   = (state_q == CLEAR);
        done      = (state_q == FINISH);
        busy      = (state_q != IDLE);
        tick      = tick_int;
        op_idx    = op_idx_q;
    end

endmodule

// File: tb/tb_mac_step_ctrl.sv
// tb_mac_step_ctrl
// Directed bench for mac_step_ctrl. Each scenario is described as per-cycle
// bit maps of stimulus and expected outputs, where bit c corresponds to the
// cycle that follows clock edge c-1 (start is driven in cycle 0 and sampled
// at edge 0). A simple MAC responder can answer each accept with mac_done in
// the following cycle.
module tb_mac_step_ctrl;

    localparam int DIV_W = 26;
    localparam int OPS_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div_max = '0;
    logic [OPS_W-1:0] n_ops = '0;
    logic             run_mode = 1'b0;
    logic             start = 1'b0;
    logic             step = 1'b0;
    logic             abort = 1'b0;
    logic             mac_ready = 1'b0;
    logic             mac_done = 1'b0;
    logic             mac_valid;
    logic             mac_clr;
    logic [OPS_W-1:0] op_idx;
    logic             tick;
    logic             busy;
    logic             done;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [63:0] start_map, step_map, ready_map, abort_map, done_map;
    logic [63:0] exp_valid, exp_clr, exp_done, exp_tick, exp_busy;
    int          exp_idx [64];
    logic        auto_done;
    logic        accepted_prev;
    int          chg_cyc;
    logic [DIV_W-1:0] alt_div;
    logic [OPS_W-1:0] alt_n;
    logic             alt_mode;

    mac_step_ctrl #(.DIV_W(DIV_W), .OPS_W(OPS_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_max   (div_max),
        .n_ops     (n_ops),
        .run_mode  (run_mode),
        .start     (start),
        .step      (step),
        .abort     (abort),
        .mac_ready (mac_ready),
        .mac_done  (mac_done),
        .mac_valid (mac_valid),
        .mac_clr   (mac_clr),
        .op_idx    (op_idx),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] bit_at(input int c);
        logic [63:0] r;
        r = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    // Reset the scenario description to an empty, ready-high plan.
    task automatic clearPlan();
        start_map = '0;
        step_map  = '0;
        ready_map = '1;
        abort_map = '0;
        done_map  = '0;
        exp_valid = '0;
        exp_clr   = '0;
        exp_done  = '0;
        exp_tick  = '0;
        exp_busy  = '0;
        for (int i = 0; i < 64; i++) exp_idx[i] = -1;
        auto_done     = 1'b1;
        accepted_prev = 1'b0;
        chg_cyc       = -1;
        alt_div       = '0;
        alt_n         = '0;
        alt_mode      = 1'b0;
    endtask

    // Drive the inputs for cycle c from the plan.
    task automatic applyStimulus(input int c);
        start     = start_map[c];
        step      = step_map[c];
        mac_ready = ready_map[c];
        abort     = abort_map[c];
        mac_done  = done_map[c] | (auto_done & accepted_prev);
        if (c == chg_cyc) begin
            div_max  = alt_div;
            n_ops    = alt_n;
            run_mode = alt_mode;
        end
    endtask

    task automatic checkCycle(input string name, input int c);
        checkOutput($sformatf("%s c%0d mac_valid", name, c), 32'(mac_valid), 32'(exp_valid[c]));
        checkOutput($sformatf("%s c%0d mac_clr", name, c), 32'(mac_clr), 32'(exp_clr[c]));
        checkOutput($sformatf("%s c%0d done", name, c), 32'(done), 32'(exp_done[c]));
        checkOutput($sformatf("%s c%0d tick", name, c), 32'(tick), 32'(exp_tick[c]));
        checkOutput($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(exp_busy[c]));
        if (exp_idx[c] >= 0) begin
            checkOutput($sformatf("%s c%0d op_idx", name, c), 32'(op_idx), 32'(exp_idx[c]));
        end
        accepted_prev = mac_valid & mac_ready;
    endtask

    task automatic runPlan(input string name, input int last);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(c);
            checkCycle(name, c);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " mac_valid"}, 32'(mac_valid), 32'd0);
        checkOutput({name, " mac_clr"}, 32'(mac_clr), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd0);
        checkOutput({name, " tick"}, 32'(tick), 32'd0);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " op_idx"}, 32'(op_idx), 32'd0);
    endtask

    initial begin
        // Reset values while rst_n is held low.
        #12;
        checkAllZero("reset");
        #10;
        rst_n = 1'b1;

        // Free-run: 3 ops every 5 cycles; mid-run input changes and a step
        // edge must have no effect.
        clearPlan();
        div_max = 26'd4; n_ops = 8'd3; run_mode = 1'b1;
        start_map = bit_at(0);
        step_map  = rng(3, 4);
        chg_cyc = 3; alt_div = 26'd9; alt_n = 8'd1; alt_mode = 1'b0;
        exp_valid = bit_at(7) | bit_at(12) | bit_at(17);
        exp_clr   = bit_at(1);
        exp_done  = bit_at(19);
        exp_tick  = bit_at(6) | bit_at(11) | bit_at(16);
        exp_busy  = rng(1, 19);
        exp_idx[7] = 0; exp_idx[12] = 1; exp_idx[17] = 2; exp_idx[20] = 2;
        runPlan("freerun", 22);

        // Single-step: one op per rising edge of step; ticks are ignored.
        clearPlan();
        div_max = 26'd3; n_ops = 8'd2; run_mode = 1'b0;
        start_map = bit_at(0);
        step_map  = rng(3, 12) | rng(16, 20);
        exp_valid = bit_at(4) | bit_at(17);
        exp_clr   = bit_at(1);
        exp_done  = bit_at(19);
        exp_tick  = bit_at(5) | bit_at(9) | bit_at(13) | bit_at(17);
        exp_busy  = rng(1, 19);
        exp_idx[4] = 0; exp_idx[6] = 1; exp_idx[17] = 1;
        runPlan("step", 22);

        // Backpressure: ready low for 7 ISSUE cycles; stray mac_done in ISSUE
        // (including the accept cycle) and start while busy are ignored.
        clearPlan();
        div_max = 26'd0; n_ops = 8'd1; run_mode = 1'b1;
        start_map = bit_at(0) | bit_at(6);
        ready_map = rng(10, 63);
        done_map  = bit_at(5) | bit_at(10);
        exp_valid = rng(3, 10);
        exp_clr   = bit_at(1);
        exp_done  = bit_at(12);
        exp_tick  = rng(2, 11);
        exp_busy  = rng(1, 12);
        for (int i = 1; i <= 12; i++) exp_idx[i] = 0;
        runPlan("backpressure", 14);

        // Zero ops: done straight away, no clear and no request.
        clearPlan();
        div_max = 26'd5; n_ops = 8'd0; run_mode = 1'b1;
        start_map = bit_at(0);
        exp_done  = bit_at(1);
        exp_busy  = bit_at(1);
        exp_idx[1] = 0; exp_idx[2] = 0;
        runPlan("zeroops", 4);

        // Abort in WAIT_DONE of op 1, then restart a one-op run.
        clearPlan();
        div_max = 26'd2; n_ops = 8'd3; run_mode = 1'b1;
        auto_done = 1'b0;
        start_map = bit_at(0) | bit_at(10);
        done_map  = bit_at(6) | bit_at(16);
        abort_map = bit_at(9);
        chg_cyc = 10; alt_div = 26'd2; alt_n = 8'd1; alt_mode = 1'b1;
        exp_valid = bit_at(5) | bit_at(8) | bit_at(15);
        exp_clr   = bit_at(1) | bit_at(11);
        exp_done  = bit_at(17);
        exp_tick  = bit_at(4) | bit_at(7) | bit_at(14);
        exp_busy  = rng(1, 9) | rng(11, 17);
        exp_idx[5] = 0; exp_idx[8] = 1; exp_idx[9] = 1; exp_idx[10] = 1;
        exp_idx[11] = 0; exp_idx[15] = 0;
        runPlan("abort", 19);

        // Reset while a request is pending: outputs drop without a clock edge.
        clearPlan();
        div_max = 26'd0; n_ops = 8'd1; run_mode = 1'b1;
        start_map = bit_at(0);
        ready_map = '0;
        exp_valid = rng(3, 5);
        exp_clr   = bit_at(1);
        exp_tick  = rng(2, 5);
        exp_busy  = rng(1, 5);
        runPlan("midreset", 5);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset async");
        #10;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("after reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
